// File: rtl/envelope_sequencer.sv
// Time-multiplexed ADSR envelope sequencer: one oscillator visited per clock after each
// sample tick, per-oscillator state/stage/count held in a shared table.
module envelope_sequencer #(
  parameter int N_OSC   = 16,
  parameter int ENV_LEN = 8,
  parameter int GAIN_W  = 32,
  parameter int DUR_W   = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sample_tick,
  input  logic [N_OSC-1:0]           key_on,
  input  logic                       cfg_we,
  input  logic [$clog2(N_OSC)-1:0]   cfg_osc,
  input  logic [$clog2(ENV_LEN)-1:0] cfg_stage,
  input  logic [GAIN_W-1:0]          cfg_gain,
  input  logic [DUR_W-1:0]           cfg_dur,
  output logic                       out_valid,
  output logic [$clog2(N_OSC)-1:0]   out_osc,
  output logic [GAIN_W-1:0]          out_gain,
  output logic                       busy,
  output logic                       overrun
);
  localparam int OW = $clog2(N_OSC);
  localparam int SW = $clog2(ENV_LEN);
  localparam logic [SW-1:0] S_HOLD = SW'(ENV_LEN - 2);
  localparam logic [SW-1:0] S_REL  = SW'(ENV_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD, ST_REL} env_state_t;

  env_state_t        r_state [N_OSC];
  logic [SW-1:0]     r_stage [N_OSC];
  logic [DUR_W-1:0]  r_count [N_OSC];
  logic [GAIN_W-1:0] r_gain  [N_OSC][ENV_LEN];
  logic [DUR_W-1:0]  r_dur   [N_OSC][ENV_LEN];

  logic              r_busy;
  logic              r_valid;
  logic [OW-1:0]     r_idx;
  logic [GAIN_W-1:0] r_gain_q;
  logic              r_overrun;

  logic              w_start, w_visit, w_key, w_more, w_cfg_ok;
  logic [OW-1:0]     w_vidx;
  env_state_t        w_cur_st, w_nxt_st;
  logic [SW-1:0]     w_cur_stage, w_nxt_stage;
  logic [DUR_W-1:0]  w_cur_cnt, w_nxt_cnt, w_cnt_inc, w_dur, w_dur_eff;
  logic [GAIN_W-1:0] w_gain;
  logic [OW:0]       w_osc_ext;
  logic [SW:0]       w_stage_ext;

  // Outputs are registered, so oscillator k is evaluated in the cycle before it is emitted.
  assign w_start = sample_tick & ~r_busy;
  assign w_visit = w_start | (r_busy & (r_idx != OW'(N_OSC - 1)));
  assign w_vidx  = w_start ? '0 : r_idx + OW'(1);

  always_comb begin
    w_cur_st    = r_state[w_vidx];
    w_cur_stage = r_stage[w_vidx];
    w_cur_cnt   = r_count[w_vidx];
    w_key       = key_on[w_vidx];
    w_dur       = r_dur[w_vidx][w_cur_stage];
    w_dur_eff   = (w_dur == '0) ? DUR_W'(1) : w_dur;
    w_more      = w_cur_cnt < w_dur_eff;
    w_cnt_inc   = (&w_cur_cnt) ? w_cur_cnt : w_cur_cnt + DUR_W'(1);
    w_nxt_st    = w_cur_st;
    w_nxt_stage = w_cur_stage;
    w_nxt_cnt   = w_cur_cnt;
    case (w_cur_st)
      ST_IDLE: if (w_key) begin
        w_nxt_st = ST_RUN; w_nxt_stage = '0; w_nxt_cnt = DUR_W'(1);
      end
      ST_RUN: begin
        if (!w_key) begin
          w_nxt_st = ST_REL; w_nxt_stage = S_REL; w_nxt_cnt = DUR_W'(1);
        end else if (w_more) begin
          w_nxt_cnt = w_cnt_inc;
        end else if (w_cur_stage < S_HOLD) begin
          w_nxt_stage = w_cur_stage + SW'(1); w_nxt_cnt = DUR_W'(1);
        end else begin
          w_nxt_st = ST_HOLD;
        end
      end
      ST_HOLD: if (!w_key) begin
        w_nxt_st = ST_REL; w_nxt_stage = S_REL; w_nxt_cnt = DUR_W'(1);
      end
      ST_REL: begin
        if (w_key) begin
          w_nxt_st = ST_RUN; w_nxt_stage = '0; w_nxt_cnt = DUR_W'(1);
        end else if (w_more) begin
          w_nxt_cnt = w_cnt_inc;
        end else begin
          w_nxt_st = ST_IDLE; w_nxt_stage = '0; w_nxt_cnt = '0;
        end
      end
      default: ;
    endcase
    // Gain always follows the state being entered; HOLD keeps stage ENV_LEN-2.
    w_gain = (w_nxt_st == ST_IDLE) ? '0 : r_gain[w_vidx][w_nxt_stage];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_gain_q  <= '0;
      r_overrun <= 1'b0;
      for (int unsigned i = 0; i < N_OSC; i++) begin
        r_state[i] <= ST_IDLE;
        r_stage[i] <= '0;
        r_count[i] <= '0;
      end
    end else begin
      if (sample_tick && r_busy) r_overrun <= 1'b1;
      r_busy  <= w_visit;
      r_valid <= w_visit;
      if (w_visit) begin
        r_idx            <= w_vidx;
        r_gain_q         <= w_gain;
        r_state[w_vidx]  <= w_nxt_st;
        r_stage[w_vidx]  <= w_nxt_stage;
        r_count[w_vidx]  <= w_nxt_cnt;
      end else begin
        r_gain_q <= '0;
      end
    end
  end

  assign w_osc_ext   = {1'b0, cfg_osc};
  assign w_stage_ext = {1'b0, cfg_stage};
  assign w_cfg_ok    = (w_osc_ext < (OW+1)'(N_OSC)) && (w_stage_ext < (SW+1)'(ENV_LEN));

  always_ff @(posedge clk) begin
    if (cfg_we && w_cfg_ok) begin
      r_gain[cfg_osc][cfg_stage] <= cfg_gain;
      r_dur[cfg_osc][cfg_stage]  <= cfg_dur;
    end
  end

  assign out_valid = r_valid;
  assign out_osc   = r_idx;
  assign out_gain  = r_gain_q;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_envelope_sequencer.sv
// Directed bench for envelope_sequencer: reset, attack/hold, release, retrigger,
// config read/write collision and overrun, with hand-computed expected gains.
module tb_envelope_sequencer;
  logic        clk, rstn, sample_tick, cfg_we;
  logic [15:0] key_on;
  logic [3:0]  cfg_osc;
  logic [2:0]  cfg_stage;
  logic [31:0] cfg_gain, cfg_dur;
  logic        out_valid, busy, overrun;
  logic [3:0]  out_osc;
  logic [31:0] out_gain;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] cap [16];
  logic        vok, bok;
  int          exp_att [10] = '{10, 10, 11, 12, 13, 14, 15, 16, 16, 16};
  int          exp_rel [5]  = '{5, 5, 5, 0, 0};

  envelope_sequencer #(.N_OSC(16), .ENV_LEN(8), .GAIN_W(32), .DUR_W(32)) dut (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick), .key_on(key_on),
    .cfg_we(cfg_we), .cfg_osc(cfg_osc), .cfg_stage(cfg_stage),
    .cfg_gain(cfg_gain), .cfg_dur(cfg_dur),
    .out_valid(out_valid), .out_osc(out_osc), .out_gain(out_gain),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cfg_write(input int osc, input int stage, input int g, input int d);
    cfg_we = 1'b1; cfg_osc = 4'(osc); cfg_stage = 3'(stage);
    cfg_gain = 32'(g); cfg_dur = 32'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One full sweep from a negedge; gains captured per oscillator. cfg_at / tick_at
  // place a write to osc 2 stage 0 or an extra tick in the cycle oscillator N is evaluated.
  task automatic sweep(input int cfg_at, input int tick_at, input int cg);
    vok = 1'b1; bok = 1'b1;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cap[k] = out_gain;
      if (!(out_valid === 1'b1 && out_osc === 4'(k))) vok = 1'b0;
      if (busy !== 1'b1) bok = 1'b0;
      sample_tick = (k + 1 == tick_at);
      cfg_we = (k + 1 == cfg_at);
      cfg_osc = 4'd2; cfg_stage = 3'd0; cfg_gain = 32'(cg); cfg_dur = 32'd100;
      @(negedge clk);
    end
    sample_tick = 1'b0; cfg_we = 1'b0;
    if (out_valid !== 1'b0) vok = 1'b0;
    if (busy !== 1'b0) bok = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; sample_tick = 1'b0; key_on = '0; cfg_we = 1'b0;
    cfg_osc = '0; cfg_stage = '0; cfg_gain = '0; cfg_dur = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_osc", 32'(out_osc), 0);
    check("rst_gain", out_gain, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 7; s++) cfg_write(3, s, 10 + s, (s == 0) ? 2 : 1);
    cfg_write(3, 7, 5, 3);
    cfg_write(2, 0, 50, 100);

    sweep(0, 0, 0);
    check("idle_vld", 32'(vok), 1);
    check("idle_busy", 32'(bok), 1);
    for (int k = 0; k < 16; k++) check("idle_gain", cap[k], 0);

    key_on[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sweep(0, 0, 0);
      check("attack_gain", cap[3], 32'(exp_att[i]));
    end
    check("attack_other", cap[4], 0);

    key_on[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sweep(0, 0, 0);
      check("release_gain", cap[3], 32'(exp_rel[i]));
    end
    key_on[3] = 1'b1;
    sweep(0, 0, 0);
    check("from_idle_gain", cap[3], 10);

    key_on[3] = 1'b0;
    sweep(0, 0, 0);
    check("retrig_rel1", cap[3], 5);
    key_on[3] = 1'b1;
    sweep(0, 0, 0);
    check("retrig_gain", cap[3], 10);
    sweep(0, 0, 0);
    check("retrig_s0", cap[3], 10);
    sweep(0, 0, 0);
    check("retrig_s1", cap[3], 11);

    key_on[2] = 1'b1;
    sweep(2, 0, 99);
    check("collide_old", cap[2], 50);
    sweep(0, 0, 0);
    check("collide_new", cap[2], 99);

    check("ovr_before", 32'(overrun), 0);
    sweep(0, 5, 0);
    check("ovr_vld", 32'(vok), 1);
    check("ovr_busy", 32'(bok), 1);
    check("ovr_flag", 32'(overrun), 1);
    vok = 1'b1;
    repeat (4) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) vok = 1'b0;
      @(negedge clk);
    end
    check("ovr_dropped", 32'(vok), 1);
    sweep(0, 0, 0);
    check("ovr_sticky", 32'(overrun), 1);
    check("ovr_next_vld", 32'(vok), 1);

    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    repeat (5) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_overrun", 32'(overrun), 0);
    check("mid_rst_gain", out_gain, 0);
    @(negedge clk);
    rstn = 1'b1;
    key_on = '0;
    @(negedge clk);
    sweep(0, 0, 0);
    check("post_rst_vld", 32'(vok), 1);
    for (int k = 0; k < 16; k++) check("post_rst_gain", cap[k], 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/envelope_sequencer.md
Name: envelope_sequencer

Overview:
- Time-multiplexed ADSR-style envelope controller that sequences per-oscillator envelope stages for the wave generator bank.
- Once per sample tick it sweeps all oscillators, one per clock. Each visit updates that oscillator's stage and duration counter and emits the current gain to the shared gain multiplier.
- Stage gains and durations are loaded from the SPI-received synth configuration through a write port.

Parameters:
N_OSC, 16, number of oscillators swept (matches `N_OSCILLATORS)
ENV_LEN, 8, envelope stages per oscillator (matches `ENVELOPE_LEN); must be at least 2
GAIN_W, 32, gain word width
DUR_W, 32, duration word width, counted in sample ticks

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle strobe that starts a sweep
key_on  in  N_OSC  per-oscillator gate level; sampled when that oscillator is visited
cfg_we  in  1  configuration write strobe
cfg_osc  in  $clog2(N_OSC)  oscillator index of the configuration write
cfg_stage  in  $clog2(ENV_LEN)  stage index of the configuration write
cfg_gain  in  GAIN_W  stage gain value
cfg_dur  in  DUR_W  stage duration value
out_valid  out  1  out_osc and out_gain are valid this cycle
out_osc  out  $clog2(N_OSC)  index of the oscillator being emitted
out_gain  out  GAIN_W  current envelope gain for out_osc
busy  out  1  sweep in progress
overrun  out  1  sticky flag: a sample_tick arrived while busy

Behaviour:
- Reset (rstn=0, asynchronous): every oscillator goes to IDLE with stage=0 and count=0. out_valid=0, out_osc=0, out_gain=0, busy=0, overrun=0. The gain/duration RAM contents are not reset.
- Sweep timing: sample_tick sampled high in cycle t with busy=0 makes busy=1 from t+1 through t+N_OSC. In cycle t+1+k, out_valid=1 and out_osc=k. out_valid=0 at all other times.
- Per-oscillator state: IDLE, RUN, HOLD, REL. Each oscillator also holds stage (ENV_LEN index) and count (DUR_W bits). Duration value d means the stage lasts max(d,1) visits.
- Each visit evaluates the current state with key_on[k] as sampled in that cycle:
  - IDLE, key=0: emit 0; stay IDLE.
  - IDLE, key=1: emit gain[0]; go to RUN with stage=0, count=1.
  - RUN, key=1: emit gain[stage].
    - If count < max(dur[stage],1): count++.
    - Else if stage < ENV_LEN-2: stage++, count=1.
    - Else: go to HOLD.
  - HOLD, key=1: emit gain[ENV_LEN-2]; no counter change.
  - RUN or HOLD, key=0: emit gain[ENV_LEN-1]; go to REL with stage=ENV_LEN-1, count=1.
  - REL, key=0: emit gain[ENV_LEN-1].
    - If count < max(dur,1): count++.
    - Else: go to IDLE, stage=0, count=0.
  - REL, key=1 (retrigger): emit gain[0]; go to RUN with stage=0, count=1.
- The emitted gain is the gain of the state entered on that visit. The IDLE-from-REL transition emits the release gain on its last visit and 0 from the next visit on.
- count saturates at all-ones and never wraps.
- Configuration writes:
  - cfg_we is accepted in any cycle, including mid-sweep, and writes {gain,dur}[cfg_osc][cfg_stage].
  - A write that targets the entry being read in the same cycle returns the old value. The new value is visible from the next visit.
  - Out-of-range cfg_osc is ignored.
- sample_tick while busy=1 is dropped (no queued sweep) and sets overrun=1. overrun clears only on reset.
- sample_tick in the cycle busy falls (t+N_OSC) counts as busy and is dropped.
- Reset asserted mid-sweep: outputs clear immediately and the partial sweep is abandoned.
- Single shared state/counter RAM: one read and one write per cycle.

Test Plan:
- Reset: rstn low mid-sweep -> out_valid=0, busy=0, overrun=0 immediately; after release the first sweep emits out_gain=0 for all 16 oscillators.
- Attack/hold: osc 3 with gain[0..6]=10..16, dur[0]=2, dur[1..5]=1, key_on[3]=1 held -> per-sweep gains 10,10,11,12,13,14,15,16,16,16... at out_osc=3, cycle t+4 after each tick.
- Release: with osc 3 in HOLD, gain[7]=5, dur[7]=3, key_on[3]=0 -> gains 5,5,5,0,0; state returns to IDLE.
- Retrigger: key_on[3] raised on the 2nd release sweep -> that sweep emits 10 and sequencing restarts at stage 0.
- Overrun: sample_tick at t and again at t+5 (N_OSC=16) -> second tick ignored, overrun=1 and stays set; sweep completes at t+16.
- Config collision: cfg_we writing osc 2 stage 0 gain=99 in the cycle osc 2 is read -> old gain emitted; next sweep emits 99.
